// File: rtl/counter_pkg.sv
// Shared types and constants for the counter library (up counters and the
// mod-N down timer).
package counter_pkg;

   // Default datapath width used by the counters when no override is given.
   localparam int COUNTER_DEFAULT_WIDTH = 8;

   // Down-timer control states.
   typedef enum logic [1:0] {
      TMR_IDLE = 2'd0,
      TMR_RUN  = 2'd1,
      TMR_DONE = 2'd2
   } timer_state_t;

endpackage : counter_pkg

// File: rtl/modn_down_timer.sv
// Loadable mod-N down counter/timer. An accepted start latches load_val as
// the terminal value N-1. Each enabled tick in RUN moves the count one step
// toward zero. The tick that consumes count==0 raises a one-cycle tc pulse.
// After that tick the timer either reloads and keeps running, or parks in DONE.
module modn_down_timer
   import counter_pkg::*;
#(
   parameter int WIDTH = COUNTER_DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             stop,
   input  logic             en,
   input  logic             auto_reload,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] count,
   output logic             busy,
   output logic             tc,
   output logic             done
);

   timer_state_t     r_state;
   logic [WIDTH-1:0] r_count;
   logic [WIDTH-1:0] r_reload;
   logic             r_tc;

   timer_state_t     w_stateNext;
   logic [WIDTH-1:0] w_countNext;
   logic [WIDTH-1:0] w_reloadNext;
   logic             w_tcNext;

   // Register state, count, reload value and tc pulse; synchronous reset clears all.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= TMR_IDLE;
         r_count  <= '0;
         r_reload <= '0;
         r_tc     <= 1'b0;
      end else begin
         r_state  <= w_stateNext;
         r_count  <= w_countNext;
         r_reload <= w_reloadNext;
         r_tc     <= w_tcNext;
      end
   end

   // Next-state and datapath decisions, priority stop > start > en tick.
   always_comb begin
      w_stateNext  = r_state;
      w_countNext  = r_count;
      w_reloadNext = r_reload;
      w_tcNext     = 1'b0;

      unique case (r_state)
         TMR_IDLE: begin
            if (start) begin
               w_reloadNext = load_val;
               w_countNext  = load_val;
               w_stateNext  = TMR_RUN;
            end
         end

         TMR_RUN: begin
            if (stop) begin
               w_stateNext = TMR_IDLE;
            end else if (start) begin
               w_reloadNext = load_val;
               w_countNext  = load_val;
            end else if (en) begin
               if (r_count == '0) begin
                  w_tcNext = 1'b1;
                  if (auto_reload) begin
                     w_countNext = r_reload;
                  end else begin
                     w_stateNext = TMR_DONE;
                  end
               end else begin
                  w_countNext = r_count - WIDTH'(1);
               end
            end
         end

         TMR_DONE: begin
            if (stop) begin
               w_stateNext = TMR_IDLE;
            end else if (start) begin
               w_reloadNext = load_val;
               w_countNext  = load_val;
               w_stateNext  = TMR_RUN;
            end
         end

         default: begin
            w_stateNext = TMR_IDLE;
         end
      endcase
   end

   assign count = r_count;
   assign busy  = (r_state == TMR_RUN);
   assign done  = (r_state == TMR_DONE);
   assign tc    = r_tc;

endmodule : modn_down_timer

// File: tb/tb_modn_down_timer.sv
// Scoreboard bench for modn_down_timer (WIDTH=4). The driver applies one
// directed vector per cycle on the falling edge and queues the outputs
// expected after the next rising edge. The monitor pops and compares them.
module tb_modn_down_timer;

   localparam int W = 4;

   typedef struct {
      logic [W-1:0] count;
      logic         busy;
      logic         tc;
      logic         done;
      string        name;
   } expect_t;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic         stop;
   logic         en;
   logic         auto_reload;
   logic [W-1:0] load_val;
   logic [W-1:0] count;
   logic         busy;
   logic         tc;
   logic         done;

   expect_t expQ[$];
   int      checkCount = 0;
   int      passCount  = 0;

   modn_down_timer #(.WIDTH(W)) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .stop        (stop),
      .en          (en),
      .auto_reload (auto_reload),
      .load_val    (load_val),
      .count       (count),
      .busy        (busy),
      .tc          (tc),
      .done        (done)
   );

   // Free-running 10-unit clock.
   always #5 clk = ~clk;

   // Drive one cycle of inputs and queue the outputs expected after the next rising edge.
   task automatic applyStimulus(input logic iRst, input logic iStart, input logic iStop,
                                input logic iEn, input logic iAr, input logic [W-1:0] iLv,
                                input logic [W-1:0] eCount, input logic eBusy,
                                input logic eTc, input logic eDone, input string nm);
      expect_t e;
      @(negedge clk);
      rst         = iRst;
      start       = iStart;
      stop        = iStop;
      en          = iEn;
      auto_reload = iAr;
      load_val    = iLv;
      e.count = eCount;
      e.busy  = eBusy;
      e.tc    = eTc;
      e.done  = eDone;
      e.name  = nm;
      expQ.push_back(e);
   endtask

   // Compare one output field against its expected value.
   task automatic checkOutput(input string nm, input string field,
                              input logic [W-1:0] got, input logic [W-1:0] exp);
      checkCount++;
      if (got === exp) begin
         passCount++;
      end else begin
         $display("[TB] FAIL %s.%s: got %0d expected %0d", nm, field, got, exp);
      end
   endtask

   // Monitor: one rising edge of the clock presents one set of registered outputs.
   initial begin
      expect_t e;
      forever begin
         @(posedge clk);
         #1;
         if (expQ.size() > 0) begin
            e = expQ.pop_front();
            checkOutput(e.name, "count", count, e.count);
            checkOutput(e.name, "busy", W'(busy), W'(e.busy));
            checkOutput(e.name, "tc", W'(tc), W'(e.tc));
            checkOutput(e.name, "done", W'(done), W'(e.done));
         end
      end
   end

   // Directed stimulus with hand-computed expectations.
   initial begin
      int waitCycles;
      rst = 1'b1; start = 1'b0; stop = 1'b0; en = 1'b0; auto_reload = 1'b0; load_val = '0;

      // Power-on reset
      applyStimulus(1, 0, 0, 0, 0, 4'd0, 4'd0, 0, 0, 0, "reset");
      applyStimulus(0, 0, 0, 0, 0, 4'd0, 4'd0, 0, 0, 0, "idle");

      // Reset mid-count: rst overrides a coincident start and en
      applyStimulus(0, 1, 0, 0, 0, 4'd9, 4'd9, 1, 0, 0, "rmStart");
      applyStimulus(0, 0, 0, 1, 0, 4'd9, 4'd8, 1, 0, 0, "rmTick1");
      applyStimulus(0, 0, 0, 1, 0, 4'd9, 4'd7, 1, 0, 0, "rmTick2");
      applyStimulus(0, 0, 0, 1, 0, 4'd9, 4'd6, 1, 0, 0, "rmTick3");
      applyStimulus(1, 1, 0, 1, 0, 4'd9, 4'd0, 0, 0, 0, "rmReset");
      applyStimulus(0, 0, 0, 0, 0, 4'd9, 4'd0, 0, 0, 0, "rmIdle");

      // One-shot, load_val=3
      applyStimulus(0, 1, 0, 0, 0, 4'd3, 4'd3, 1, 0, 0, "osStart");
      applyStimulus(0, 0, 0, 1, 0, 4'd3, 4'd2, 1, 0, 0, "osTick1");
      applyStimulus(0, 0, 0, 1, 0, 4'd3, 4'd1, 1, 0, 0, "osTick2");
      applyStimulus(0, 0, 0, 1, 0, 4'd3, 4'd0, 1, 0, 0, "osTick3");
      applyStimulus(0, 0, 0, 1, 0, 4'd3, 4'd0, 0, 1, 1, "osTerm");
      applyStimulus(0, 0, 0, 1, 0, 4'd3, 4'd0, 0, 0, 1, "osDone1");
      applyStimulus(0, 0, 0, 1, 0, 4'd3, 4'd0, 0, 0, 1, "osDone2");
      applyStimulus(0, 0, 1, 0, 0, 4'd3, 4'd0, 0, 0, 0, "osStop");

      // Auto-reload with en gaps; load_val changed mid-run must be ignored
      applyStimulus(0, 1, 0, 0, 1, 4'd2, 4'd2, 1, 0, 0, "arStart");
      applyStimulus(0, 0, 0, 1, 1, 4'd9, 4'd1, 1, 0, 0, "arE1");
      applyStimulus(0, 0, 0, 0, 1, 4'd9, 4'd1, 1, 0, 0, "arG1");
      applyStimulus(0, 0, 0, 1, 1, 4'd9, 4'd0, 1, 0, 0, "arE2");
      applyStimulus(0, 0, 0, 0, 1, 4'd9, 4'd0, 1, 0, 0, "arG2");
      applyStimulus(0, 0, 0, 1, 1, 4'd9, 4'd2, 1, 1, 0, "arTc1");
      applyStimulus(0, 0, 0, 0, 1, 4'd9, 4'd2, 1, 0, 0, "arG3");
      applyStimulus(0, 0, 0, 1, 1, 4'd9, 4'd1, 1, 0, 0, "arE3");
      applyStimulus(0, 0, 0, 0, 1, 4'd9, 4'd1, 1, 0, 0, "arG4");
      applyStimulus(0, 0, 0, 1, 1, 4'd9, 4'd0, 1, 0, 0, "arE4");
      applyStimulus(0, 0, 0, 0, 1, 4'd9, 4'd0, 1, 0, 0, "arG5");
      applyStimulus(0, 0, 0, 1, 1, 4'd9, 4'd2, 1, 1, 0, "arTc2");
      applyStimulus(0, 0, 1, 1, 1, 4'd9, 4'd2, 0, 0, 0, "arStop");

      // Modulus 1: tc every enabled cycle
      applyStimulus(0, 1, 0, 0, 1, 4'd0, 4'd0, 1, 0, 0, "m1Start");
      for (int k = 0; k < 5; k++) begin
         applyStimulus(0, 0, 0, 1, 1, 4'd0, 4'd0, 1, 1, 0, "m1Tick");
      end
      applyStimulus(0, 0, 0, 0, 1, 4'd0, 4'd0, 1, 0, 0, "m1Hold");
      applyStimulus(0, 0, 0, 1, 0, 4'd0, 4'd0, 0, 1, 1, "m1Done");
      applyStimulus(0, 0, 1, 0, 0, 4'd0, 4'd0, 0, 0, 0, "m1Stop");

      // Stop beats start; count freezes in IDLE
      applyStimulus(0, 1, 0, 0, 0, 4'd6, 4'd6, 1, 0, 0, "ssStart");
      applyStimulus(0, 0, 0, 1, 0, 4'd6, 4'd5, 1, 0, 0, "ssTick");
      applyStimulus(0, 1, 1, 1, 0, 4'd6, 4'd5, 0, 0, 0, "ssBoth");
      applyStimulus(0, 0, 1, 1, 0, 4'd6, 4'd5, 0, 0, 0, "ssIdleStop");
      applyStimulus(0, 1, 0, 0, 0, 4'd7, 4'd7, 1, 0, 0, "ssRestart");

      // Restart mid-run, run to DONE, exit via stop and via start
      applyStimulus(0, 0, 0, 1, 0, 4'd7, 4'd6, 1, 0, 0, "rdTick1");
      applyStimulus(0, 0, 0, 1, 0, 4'd7, 4'd5, 1, 0, 0, "rdTick2");
      applyStimulus(0, 0, 0, 1, 0, 4'd7, 4'd4, 1, 0, 0, "rdTick3");
      applyStimulus(0, 1, 0, 1, 0, 4'd12, 4'd12, 1, 0, 0, "rdRestart");
      for (int k = 11; k >= 0; k--) begin
         applyStimulus(0, 0, 0, 1, 0, 4'd12, W'(k), 1, 0, 0, "rdCount");
      end
      applyStimulus(0, 0, 0, 1, 0, 4'd12, 4'd0, 0, 1, 1, "rdTerm");
      applyStimulus(0, 0, 0, 0, 0, 4'd12, 4'd0, 0, 0, 1, "rdDone");
      applyStimulus(0, 0, 1, 0, 0, 4'd12, 4'd0, 0, 0, 0, "rdStop");
      applyStimulus(0, 1, 0, 0, 0, 4'd5, 4'd5, 1, 0, 0, "rdStart");
      applyStimulus(0, 1, 0, 0, 0, 4'd0, 4'd0, 1, 0, 0, "dsLoad0");
      applyStimulus(0, 0, 0, 1, 0, 4'd0, 4'd0, 0, 1, 1, "dsTerm");
      applyStimulus(0, 1, 0, 1, 0, 4'd4, 4'd4, 1, 0, 0, "dsStart");
      applyStimulus(0, 0, 0, 0, 0, 4'd4, 4'd4, 1, 0, 0, "dsHold");

      // Let the monitor drain the scoreboard, bounded
      waitCycles = 0;
      while (expQ.size() > 0 && waitCycles < 10) begin
         @(posedge clk);
         #2;
         waitCycles++;
      end
      checkCount++;
      if (expQ.size() == 0) begin
         passCount++;
      end else begin
         $display("[TB] FAIL drain: got %0d pending expected 0", expQ.size());
      end

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule : tb_modn_down_timer

// File: doc/modn_down_timer.md
Name: modN_down_timer

Overview:
Loadable mod-N down counter/timer. It is the count-down counterpart to the team's mod-N up counter.
- On start, latches a terminal value N-1 and counts down to 0 on enabled ticks.
- Emits a one-cycle terminal-count pulse, then either auto-reloads or stops in DONE.
- Used as a programmable interval/timeout generator beside the up counters in the counter library.

Parameters:
WIDTH, 8, bit width of count, load_val and the internal reload register.

Ports:
clk  input  1  clock; all logic on rising edge
rst  input  1  reset, synchronous, active-high
start  input  1  level-sampled each cycle; loads load_val and enters RUN
stop  input  1  abort; returns to IDLE
en  input  1  tick enable; count moves only when en=1 in RUN
auto_reload  input  1  sampled at the terminal tick; 1 = reload and keep running, 0 = go to DONE
load_val  input  WIDTH  terminal value N-1; period is load_val+1 enabled ticks
count  output  WIDTH  current count (registered)
busy  output  1  1 while state is RUN (registered)
tc  output  1  one-cycle pulse, the cycle after the tick that consumed count==0
done  output  1  level, 1 while state is DONE

Behaviour:
- States: IDLE, RUN, DONE.
- Reset (rst=1 at a clk edge, any state, including mid-count):
  - state=IDLE, count=0, reload_reg=0, busy=0, tc=0, done=0.
  - rst overrides all other inputs.
- Input priority in one cycle: rst > stop > start > en tick.
- IDLE:
  - start=1: reload_reg<=load_val, count<=load_val, go to RUN. busy=1 from the next cycle.
  - stop alone: no effect.
  - count holds its last value.
- RUN:
  - stop=1: go to IDLE. count freezes at its current value. tc is not asserted.
  - start=1 (no stop): restart. reload_reg<=load_val, count<=load_val, stay in RUN. A coincident en tick is ignored.
  - en=1 and count!=0: count<=count-1.
  - en=1 and count==0 (terminal tick): tc<=1 for exactly one cycle. Then:
    - auto_reload=1: count<=reload_reg, stay in RUN.
    - auto_reload=0: count stays 0, go to DONE.
  - en=0: all state holds.
- DONE:
  - done=1, busy=0, count=0.
  - start=1: reload from load_val, go to RUN, done clears next cycle.
  - stop=1: go to IDLE, done clears next cycle.
  - en is ignored.
- tc is registered and pulses exactly once per terminal tick. It is 0 in every other cycle.
- load_val=0 means modulus 1: every enabled tick is a terminal tick.
  - With auto_reload=1, tc pulses on every enabled cycle, back-to-back.
- load_val is sampled only on accepted start. Changes while running have no effect until the next start.
- Arithmetic: count is unsigned WIDTH bits. Decrement never wraps because 0 is always handled as the terminal case.
- Latency: from start to the first tc is (load_val+1) enabled ticks, plus 1 cycle for the tc register.

Decomposition:
- Shared package counter_pkg holds:
  - typedef enum for timer state (IDLE, RUN, DONE);
  - any common counter constants reused by the up counters.
- Single module, no sub-module. The down-count datapath and FSM are small enough to share one always block plus next-state logic.

Test Plan:
- Reset mid-count (WIDTH=4): start with load_val=9, 3 en ticks, then assert rst → next cycle count=0, busy=0, tc=0, done=0, state IDLE.
- One-shot: load_val=3, auto_reload=0, en=1 continuously → count goes 3,2,1,0. tc=1 for one cycle after the 4th tick. done=1 and busy=0 thereafter, count stays 0.
- Auto-reload with gaps: load_val=2, auto_reload=1, en toggling 1010… → count goes 2,2,1,1,0,0,2…. One tc pulse per 3 enabled ticks, with 6 cycles between pulses.
- Modulus 1: load_val=0, auto_reload=1, en=1 for 5 cycles → tc high 5 consecutive cycles, count stays 0, busy stays 1.
- Stop vs start priority: in RUN at count=5, assert start and stop together → next state IDLE, count=5, busy=0, no tc. Then start with load_val=7 → count=7, busy=1.
- Restart and DONE exit: in RUN at count=4, start with load_val=12 → count=12, no tc. Run to DONE. Then stop → done=0, IDLE. Then start → RUN with count=load_val.
